// File: rtl/vip_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vip_reset_sequencer
// Purpose  : Sequences N_DOM reset domains from one clock. All domain resets
//            are asserted together and held for ASSERT_CYCLES. The domains are
//            then released one at a time in index order, GAP_CYCLES apart.
//            The same sequence runs after power-on and after any single-cycle
//            request from one of N_REQ requesters.
// Ports    : clock      - sequencer clock
//            reset      - asynchronous active-low reset
//            req        - per-requester single-cycle reset request
//            rst_out_n  - per-domain active-low reset (bit k = domain k)
//            busy       - high while any domain is held in reset
//            done       - one-cycle pulse when the last domain is released
//            cause      - requesters that triggered the current/last sequence
// Revision : 1.0 - initial release
// ============================================================================
module vip_reset_sequencer #(
  parameter int N_REQ         = 4,
  parameter int N_DOM         = 3,
  parameter int ASSERT_CYCLES = 16,
  parameter int GAP_CYCLES    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_DOM-1:0] rst_out_n,
  output logic             busy,
  output logic             done,
  output logic [N_REQ-1:0] cause
);

  localparam logic [7:0] HOLD_LAST = 8'(ASSERT_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [3:0] LAST_DOM  = 4'(N_DOM - 1);

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [7:0]       cnt, cnt_nx;
  logic [3:0]       idx, idx_nx;
  logic             sync_q;
  logic [N_DOM-1:0] rst_q, rst_nx;
  logic             busy_q, busy_nx;
  logic             done_q, done_nx;
  logic [N_REQ-1:0] cause_q, cause_nx;
  logic             any_req;

  assign any_req   = |req;
  assign rst_out_n = rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cause     = cause_q;

  // Reset-release synchronizer: sync_q is the first stage and the state
  // register leaving ST_RESET acts as the second, so HOLD is entered on the
  // second clock edge after reset deasserts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q  <= 1'b0;
      state   <= ST_RESET;
      cnt     <= 8'd0;
      idx     <= 4'd0;
      rst_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      cause_q <= '0;
    end else begin
      sync_q  <= 1'b1;
      state   <= state_nx;
      cnt     <= cnt_nx;
      idx     <= idx_nx;
      rst_q   <= rst_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
      cause_q <= cause_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    rst_nx   = rst_q;
    busy_nx  = busy_q;
    done_nx  = 1'b0;
    cause_nx = cause_q;

    case (state)
      ST_RESET: begin
        if (sync_q) begin
          state_nx = ST_HOLD;
          cnt_nx   = 8'd0;
          idx_nx   = 4'd0;
        end
      end

      ST_HOLD: begin
        if (any_req) begin
          // A request while holding simply restarts the hold period.
          cnt_nx   = 8'd0;
          cause_nx = cause_q | req;
        end else if (cnt == HOLD_LAST) begin
          rst_nx[0] = 1'b1;
          cnt_nx    = 8'd0;
          idx_nx    = 4'd1;
          if (N_DOM == 1) begin
            state_nx = ST_RUN;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
          end else begin
            state_nx = ST_RELEASE;
          end
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end

      ST_RELEASE: begin
        // Request takes priority over a release on the same edge, including
        // the release of the last domain.
        if (any_req) begin
          state_nx = ST_HOLD;
          cnt_nx   = 8'd0;
          idx_nx   = 4'd0;
          rst_nx   = '0;
          cause_nx = cause_q | req;
        end else if (cnt == GAP_LAST) begin
          for (int k = 0; k < N_DOM; k++) begin
            if (4'(k) == idx) begin
              rst_nx[k] = 1'b1;
            end
          end
          cnt_nx = 8'd0;
          idx_nx = idx + 4'd1;
          if (idx == LAST_DOM) begin
            state_nx = ST_RUN;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
          end
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end

      ST_RUN: begin
        if (any_req) begin
          state_nx = ST_HOLD;
          cnt_nx   = 8'd0;
          idx_nx   = 4'd0;
          rst_nx   = '0;
          busy_nx  = 1'b1;
          cause_nx = req;
        end
      end

      default: begin
        state_nx = ST_RESET;
      end
    endcase
  end

endmodule
`default_nettype wire
